// File: rtl/fc_sched.sv
// fc_sched: sequencing controller for the fully-connected input-stationary PE chain.
// Loads one ifmap vector into the chain, streams weight rows, and tags finished psums.
// Optional feature macro: FC_SCHED_IFMAP_REUSE_EN (adds reuse_ifmap, skips LOAD).
module fc_sched #(
    parameter int NUM_PE = 8,
    parameter int ROW_W  = 8,
    parameter int IA_W   = $clog2(NUM_PE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ROW_W-1:0] num_rows,
`ifdef FC_SCHED_IFMAP_REUSE_EN
    input  logic             reuse_ifmap,
`endif
    output logic             busy,
    output logic             done,
    output logic             ifmap_rd_en,
    output logic [IA_W-1:0]  ifmap_rd_addr,
    output logic             pe_load,
    output logic             w_rd_en,
    output logic [ROW_W-1:0] w_rd_row,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row
);

    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;

    state_t                       state_q, state_d;
    logic [ROW_W-1:0]             m_q, m_d;
    logic [ROW_W-1:0]             row_q, row_d;
    logic [IA_W-1:0]              addr_q, addr_d;
    logic                         pe_load_q, pe_load_d;
    logic                         zdone_q, zdone_d;
    // {valid,row} travels NUM_PE+1 stages from the weight read to the chain output
    logic [NUM_PE:0]              vld_pipe_q, vld_pipe_d;
    logic [NUM_PE:0][ROW_W-1:0]   row_pipe_q, row_pipe_d;
    logic                         last_out;
    logic                         skip_load;

`ifdef FC_SCHED_IFMAP_REUSE_EN
    assign skip_load = reuse_ifmap;
`else
    assign skip_load = 1'b0;
`endif

    // final row of the job emerging from the last PE
    assign last_out = vld_pipe_q[NUM_PE] && (row_pipe_q[NUM_PE] == m_q - ROW_W'(1));

    // next-state, counters and read strobes
    always_comb begin
        state_d       = state_q;
        m_d           = m_q;
        row_d         = row_q;
        addr_d        = addr_q;
        zdone_d       = 1'b0;
        ifmap_rd_en   = 1'b0;
        ifmap_rd_addr = '0;
        w_rd_en       = 1'b0;
        w_rd_row      = '0;
        case (state_q)
            IDLE: begin
                // a zero-row pulse still in flight counts as the done cycle, so start is ignored
                if (start && !zdone_q) begin
                    if (num_rows == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        m_d    = num_rows;
                        row_d  = '0;
                        addr_d = IA_W'(NUM_PE - 1);
                        state_d = skip_load ? COMPUTE : LOAD;
                    end
                end
            end
            LOAD: begin
                ifmap_rd_en   = 1'b1;
                ifmap_rd_addr = addr_q;
                if (addr_q == '0) state_d = COMPUTE;
                else              addr_d  = addr_q - IA_W'(1);
            end
            COMPUTE: begin
                w_rd_en  = 1'b1;
                w_rd_row = row_q;
                if (row_q == m_q - ROW_W'(1)) state_d = DRAIN;
                else                          row_d   = row_q + ROW_W'(1);
            end
            DRAIN: begin
                if (last_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // result-tracking shift register and delayed load strobe
    always_comb begin
        vld_pipe_d    = {vld_pipe_q[NUM_PE-1:0], w_rd_en};
        row_pipe_d    = row_pipe_q;
        row_pipe_d[0] = w_rd_row;
        for (int i = 1; i <= NUM_PE; i++) row_pipe_d[i] = row_pipe_q[i-1];
        pe_load_d     = ifmap_rd_en;
    end

    // registered-state-derived outputs
    always_comb begin
        busy      = (state_q != IDLE);
        pe_load   = pe_load_q;
        out_valid = vld_pipe_q[NUM_PE];
        out_row   = vld_pipe_q[NUM_PE] ? row_pipe_q[NUM_PE] : '0;
        done      = zdone_q || (state_q == DRAIN && last_out);
    end

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            m_q        <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            pe_load_q  <= 1'b0;
            zdone_q    <= 1'b0;
            vld_pipe_q <= '0;
            row_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            pe_load_q  <= pe_load_d;
            zdone_q    <= zdone_d;
            vld_pipe_q <= vld_pipe_d;
            row_pipe_q <= row_pipe_d;
        end
    end

endmodule

// File: tb/tb_fc_sched.sv
// tb_fc_sched: self-checking bench for fc_sched (NUM_PE=4, ROW_W=8).
// Expected outputs come from the job timeline expressed relative to the accepted start.
module tb_fc_sched;

    localparam int N     = 4;
    localparam int ROW_W = 8;
    localparam int IA_W  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [ROW_W-1:0] num_rows = '0;
`ifdef FC_SCHED_IFMAP_REUSE_EN
    logic             reuse_ifmap = 1'b0;
`endif
    logic             busy, done, ifmap_rd_en, pe_load, w_rd_en, out_valid;
    logic [IA_W-1:0]  ifmap_rd_addr;
    logic [ROW_W-1:0] w_rd_row, out_row;
    logic [23:0]      got;

    int n_checks = 0;
    int n_fail   = 0;

    fc_sched #(.NUM_PE(N), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
`ifdef FC_SCHED_IFMAP_REUSE_EN
        .reuse_ifmap(reuse_ifmap),
`endif
        .busy(busy), .done(done), .ifmap_rd_en(ifmap_rd_en), .ifmap_rd_addr(ifmap_rd_addr),
        .pe_load(pe_load), .w_rd_en(w_rd_en), .w_rd_row(w_rd_row),
        .out_valid(out_valid), .out_row(out_row)
    );

    always #5 clk = ~clk;

    assign got = {busy, done, ifmap_rd_en, ifmap_rd_addr, pe_load, w_rd_en, w_rd_row, out_valid, out_row};

    // Reference timeline: outputs at cycle c after a start accepted at cycle 0.
    function automatic logic [23:0] exp_vec(int c, int m, bit reuse);
        logic b = 0, d = 0, ie = 0, pl = 0, we = 0, ov = 0;
        logic [IA_W-1:0]  ia = '0;
        logic [ROW_W-1:0] wr = '0, orow = '0;
        int k;
        if (c >= 1) begin
            if (m == 0) begin
                d = (c == 1);
            end else begin
                k  = reuse ? c + N : c;
                b  = (k <= 2*N + m + 1);
                d  = (k == 2*N + m + 1);
                if (!reuse) begin
                    ie = (k <= N);
                    if (ie) ia = IA_W'(N - k);
                    pl = (k >= 2 && k <= N + 1);
                end
                we = (k >= N + 1 && k <= N + m);
                if (we) wr = ROW_W'(k - N - 1);
                ov = (k >= 2*N + 2 && k <= 2*N + m + 1);
                if (ov) orow = ROW_W'(k - 2*N - 2);
            end
        end
        return {b, d, ie, ia, pl, we, wr, ov, orow};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom); num_rows = ROW_W'($urandom);
            step();
            n_checks++;
            if (got !== 24'h0) begin n_fail++; $display("FAIL reset_hold cyc=%0d got=%h exp=0", i, got); end
        end
        rst = 1'b0; start = 1'b0; num_rows = '0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (got !== 24'h0) begin n_fail++; $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, got); end
        end
    endtask

    task automatic test_basic();
        num_rows = 8'd3; start = 1'b1;
        step();
        start = 1'b0; num_rows = 8'd0;
        for (int c = 1; c <= 16; c++) begin
            n_checks++;
            if (got !== exp_vec(c, 3, 0)) begin
                n_fail++; $display("FAIL basic_m3 c=%0d got=%h exp=%h", c, got, exp_vec(c, 3, 0));
            end
            step();
        end
    endtask

    task automatic test_zero_rows();
        num_rows = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (got !== exp_vec(c, 0, 0)) begin
                n_fail++; $display("FAIL zero_rows c=%0d got=%h exp=%h", c, got, exp_vec(c, 0, 0));
            end
            step();
        end
    endtask

    task automatic test_start_ignore();
        num_rows = 8'd3; start = 1'b1;
        step();
        for (int c = 1; c <= 12; c++) begin
            start = (c == 3 || c == 12);
            num_rows = ROW_W'($urandom_range(1, 200));
            n_checks++;
            if (got !== exp_vec(c, 3, 0)) begin
                n_fail++; $display("FAIL ignore_job1 c=%0d got=%h exp=%h", c, got, exp_vec(c, 3, 0));
            end
            step();
        end
        start = 1'b1; num_rows = 8'd3;
        n_checks++;
        if (got !== 24'h0) begin n_fail++; $display("FAIL ignore_gap got=%h exp=0", got); end
        step();
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            num_rows = ROW_W'($urandom);
            n_checks++;
            if (got !== exp_vec(c, 3, 0)) begin
                n_fail++; $display("FAIL ignore_job2 c=%0d got=%h exp=%h", c, got, exp_vec(c, 3, 0));
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        num_rows = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            rst = (c == 8);
            n_checks++;
            if (got !== exp_vec(c, 3, 0)) begin
                n_fail++; $display("FAIL midrst_pre c=%0d got=%h exp=%h", c, got, exp_vec(c, 3, 0));
            end
            step();
        end
        rst = 1'b0;
        for (int c = 9; c <= 20; c++) begin
            n_checks++;
            if (got !== 24'h0) begin n_fail++; $display("FAIL midrst_flush c=%0d got=%h exp=0", c, got); end
            step();
        end
        num_rows = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            n_checks++;
            if (got !== exp_vec(c, 2, 0)) begin
                n_fail++; $display("FAIL midrst_rerun c=%0d got=%h exp=%h", c, got, exp_vec(c, 2, 0));
            end
            step();
        end
    endtask

    task automatic test_random_jobs();
        int m, gap;
        for (int j = 0; j < 8; j++) begin
            m   = (j == 7) ? 255 : int'($urandom_range(1, 12));
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                n_checks++;
                if (got !== 24'h0) begin n_fail++; $display("FAIL rand_gap job=%0d got=%h exp=0", j, got); end
                step();
            end
            num_rows = ROW_W'(m); start = 1'b1;
            step();
            start = 1'b0;
            for (int c = 1; c <= 2*N + m + 3; c++) begin
                num_rows = ROW_W'($urandom);
                start    = (c < 2*N + m + 2) ? 1'($urandom) : 1'b0;
                n_checks++;
                if (got !== exp_vec(c, m, 0)) begin
                    n_fail++; $display("FAIL rand_job%0d m=%0d c=%0d got=%h exp=%h", j, m, c, got, exp_vec(c, m, 0));
                end
                step();
            end
        end
    endtask

`ifdef FC_SCHED_IFMAP_REUSE_EN
    task automatic test_reuse();
        num_rows = 8'd2; start = 1'b1; reuse_ifmap = 1'b1;
        step();
        start = 1'b0; reuse_ifmap = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            n_checks++;
            if (got !== exp_vec(c, 2, 1)) begin
                n_fail++; $display("FAIL reuse_m2 c=%0d got=%h exp=%h", c, got, exp_vec(c, 2, 1));
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_rows();
        test_start_ignore();
        test_reset_mid();
        test_random_jobs();
`ifdef FC_SCHED_IFMAP_REUSE_EN
        test_reuse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
